// File: rtl/packet_injector.sv
// Source-side network interface: converts absolute destinations to signed {dy,dx} headers,
// buffers packets in a FIFO and drives the router local port. Optional: INJECT_DROP_COUNT_EN.
module packet_injector #(
    parameter int address_length   = 16,
    parameter int x_address_length = 8,
    parameter int y_address_length = 8,
    parameter int payload_length   = 16,
    parameter int fifo_depth       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [x_address_length-1:0]              local_x,
    input  logic [y_address_length-1:0]              local_y,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [x_address_length-1:0]              in_dst_x,
    input  logic [y_address_length-1:0]              in_dst_y,
    input  logic [payload_length-1:0]                in_payload,
    output logic                                     out_valid,
    input  logic                                     out_ack,
    output logic [address_length+payload_length-1:0] out_flit,
    output logic                                     err_range,
    output logic [$clog2(fifo_depth):0]              fifo_count
`ifdef INJECT_DROP_COUNT_EN
    ,
    output logic [15:0]                              drop_count
`endif
);

    localparam int PTR_W  = $clog2(fifo_depth);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FLIT_W = address_length + payload_length;

    typedef enum logic {IDLE, SEND} state_t;

    // A (w+1)-bit difference fits in w signed bits when its top two bits agree.
    function automatic logic fits_x(input logic signed [x_address_length:0] v);
        return v[x_address_length] == v[x_address_length-1];
    endfunction

    function automatic logic fits_y(input logic signed [y_address_length:0] v);
        return v[y_address_length] == v[y_address_length-1];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                    state, state_next;
    logic [FLIT_W-1:0]         mem [fifo_depth];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      pop, push, accept, offset_ok;
    logic signed [x_address_length:0] dx_wide;
    logic signed [y_address_length:0] dy_wide;
    logic [FLIT_W-1:0]         entry;

    assign dx_wide   = $signed({1'b0, in_dst_x}) - $signed({1'b0, local_x});
    assign dy_wide   = $signed({1'b0, in_dst_y}) - $signed({1'b0, local_y});
    assign offset_ok = fits_x(dx_wide) && fits_y(dy_wide);
    assign entry     = {dy_wide[y_address_length-1:0], dx_wide[x_address_length-1:0], in_payload};

    assign in_ready   = (count != CNT_W'(fifo_depth));
    assign accept     = in_valid && in_ready;
    assign push       = accept && offset_ok;
    assign out_valid  = (state == SEND);
    assign fifo_count = count;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    if (count != '0) pop = 1'b1;
                    else state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_range <= 1'b0;
            out_flit  <= '0;
        end else begin
            state     <= state_next;
            err_range <= accept && !offset_ok;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_flit <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; occupancy and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

`ifdef INJECT_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_count <= '0;
        else if (err_range) drop_count <= sat_inc16(drop_count);
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_packet_injector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  local_x = '0, local_y = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_dst_x = '0, in_dst_y = '0;
    logic [15:0] in_payload = '0;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic [31:0] out_flit;
    logic        err_range;
    logic [2:0]  fifo_count;
`ifdef INJECT_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    packet_injector dut (
        .clk(clk), .rst(rst), .local_x(local_x), .local_y(local_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst_x(in_dst_x), .in_dst_y(in_dst_y),
        .in_payload(in_payload), .out_valid(out_valid), .out_ack(out_ack), .out_flit(out_flit),
        .err_range(err_range), .fifo_count(fifo_count)
`ifdef INJECT_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packets waiting in the buffer plus the one presented to the router.
    logic [31:0] mq[$];
    bit          held = 0;
    logic [31:0] held_flit = '0;
    bit          err_exp = 0;
    int          drops = 0;
    int          m_dx, m_dy, m_sz;
    bit          m_acc, m_ok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            held    = 0;
            err_exp = 0;
            drops   = 0;
        end else begin
            m_sz  = mq.size();
            m_acc = in_valid && (m_sz < DEPTH);
            m_dx  = int'(in_dst_x) - int'(local_x);
            m_dy  = int'(in_dst_y) - int'(local_y);
            m_ok  = (m_dx >= -128) && (m_dx <= 127) && (m_dy >= -128) && (m_dy <= 127);
            if (!held || out_ack) begin
                if (m_sz > 0) begin
                    held_flit = mq.pop_front();
                    held      = 1;
                end else begin
                    held = 0;
                end
            end
            if (m_acc && m_ok) mq.push_back({m_dy[7:0], m_dx[7:0], in_payload});
            if (err_exp && drops < 65535) drops++;
            err_exp = m_acc && !m_ok;
        end
    end

    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, held});
        check("fifo_count", {29'd0, fifo_count}, 32'(mq.size()));
        check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
        check("err_range", {31'd0, err_range}, {31'd0, err_exp});
        if (held) check("out_flit", out_flit, held_flit);
`ifdef INJECT_DROP_COUNT_EN
        check("drop_count", {16'd0, drop_count}, 32'(drops));
`endif
    end

    task automatic step(input bit v, input logic [7:0] dx, input logic [7:0] dy,
                        input logic [15:0] p, input bit a);
        in_valid   = v;
        in_dst_x   = dx;
        in_dst_y   = dy;
        in_payload = p;
        out_ack    = a;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_flit", out_flit, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        @(negedge clk);

        // Basic offset with negative dy
        local_x = 8'd2; local_y = 8'd3;
        step(1, 8'd5, 8'd1, 16'hABCD, 0);
        check("t1_valid_e1", {31'd0, out_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        check("t1_valid_e2", {31'd0, out_valid}, 32'd1);
        check("t1_flit", out_flit, 32'hFE03ABCD);
        step(0, 0, 0, 0, 1);
        check("t1_valid_after_ack", {31'd0, out_valid}, 32'd0);

        // Zero offset is delivered once
        local_x = 8'd4; local_y = 8'd4;
        step(1, 8'd4, 8'd4, 16'h1234, 1);
        step(0, 0, 0, 0, 1);
        check("t2_flit", out_flit, 32'h00001234);
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("t2_drop", {31'd0, out_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("t2_once", {31'd0, out_valid}, 32'd0);

        // Out-of-range dx is dropped
        local_x = 8'd0; local_y = 8'd0;
        step(1, 8'd200, 8'd0, 16'h5555, 0);
        check("t3_err", {31'd0, err_range}, 32'd1);
        check("t3_ready", {31'd0, in_ready}, 32'd1);
        step(0, 0, 0, 0, 0);
        check("t3_err_pulse", {31'd0, err_range}, 32'd0);
        check("t3_no_valid", {31'd0, out_valid}, 32'd0);

        // Fill: one held plus DEPTH buffered, then drain in order
        for (int k = 0; k < 5; k++) step(1, 8'(k), 8'(k), 16'(16'h0100 + k), 0);
        check("t4_full", {31'd0, in_ready}, 32'd0);
        check("t4_count", {29'd0, fifo_count}, 32'd4);
        check("t4_head", out_flit, 32'h00000100);
        for (int k = 1; k < 5; k++) begin
            step(0, 0, 0, 0, 1);
            check("t4_order", out_flit, {8'(k), 8'(k), 16'(16'h0100 + k)});
            check("t4_b2b", {31'd0, out_valid}, 32'd1);
        end
        step(0, 0, 0, 0, 1);
        check("t4_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: occupancy stays constant
        local_x = 8'd1; local_y = 8'd1;
        for (int k = 0; k < 10; k++) begin
            step(1, 8'(k + 2), 8'd3, 16'(k), 1);
            check("t5_count", {29'd0, fifo_count}, 32'd1);
            if (k >= 1) check("t5_valid", {31'd0, out_valid}, 32'd1);
        end
        repeat (3) step(0, 0, 0, 0, 1);

        // Asynchronous reset in SEND with entries queued
        for (int k = 0; k < 4; k++) step(1, 8'd9, 8'd9, 16'(k), 0);
        check("t6_pre_count", {29'd0, fifo_count}, 32'd3);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_count", {29'd0, fifo_count}, 32'd0);
        check("t6_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0] dx, dy;
            if (n % 100 == 0) begin
                local_x = 8'($urandom);
                local_y = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                dx = 8'($urandom);
                dy = 8'($urandom);
            end else begin
                dx = local_x + 8'($urandom_range(0, 40)) - 8'd20;
                dy = local_y + 8'($urandom_range(0, 40)) - 8'd20;
            end
            step($urandom_range(0, 3) != 0, dx, dy, 16'($urandom), $urandom_range(0, 9) < 7);
        end
        repeat (8) step(0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
